// File: rtl/dac_driver_pkg.sv
// Shared constants, GPIO field layout and word builder for the DAC pulse driver.
// Pure declarations: no latency, no flow control.
package dac_driver_pkg;
  localparam int num_bits         = 4;
  localparam int dac_lanes        = 8;
  localparam int dac_sample_width = 16;
  localparam int fifo_depth       = 4;

  localparam int gpio_w_clk_bit = 31;
  localparam int gpio_addr_hi   = 11;
  localparam int gpio_addr_lo   = 8;
  localparam int gpio_data_hi   = 7;
  localparam int gpio_data_lo   = 0;

  localparam logic [3:0] addr_reg      = 4'd0;
  localparam logic [3:0] data_lo_reg   = 4'd1;
  localparam logic [3:0] data_hi_reg   = 4'd2;
  localparam logic [3:0] pulse_pos_reg = 4'd3;
  localparam logic [3:0] pulse_len_reg = 4'd4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_PULSE  = 2'd2;

  typedef logic [dac_lanes*dac_sample_width-1:0] dac_word_t;

  // The first word of a pulse leaves lanes below the start position at zero.
  function automatic dac_word_t build_word(input logic [dac_sample_width-1:0] amp,
                                           input logic [2:0] pos, input logic first);
    dac_word_t w;
    w = '0;
    for (int i = 0; i < dac_lanes; i++) begin
      if (!first || i >= int'(pos)) w[i*dac_sample_width +: dac_sample_width] = amp;
    end
    return w;
  endfunction
endpackage

// File: rtl/dac_driver_if.sv
// Bundle of config, value-input and DAC stream signals between the FSM side and the driver.
// Wiring only: no latency; the stream side uses valid/ready.
interface dac_driver_if;
  import dac_driver_pkg::*;

  logic [31:0]         gpio;
  logic [num_bits-1:0] val;
  logic                val_vld;
  logic                dac_en;
  dac_word_t           m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                busy;
  logic                overflow;

  modport master (output gpio, val, val_vld, dac_en, m_axis_tready,
                  input  m_axis_tdata, m_axis_tvalid, busy, overflow);
  modport slave  (input  gpio, val, val_vld, dac_en, m_axis_tready,
                  output m_axis_tdata, m_axis_tvalid, busy, overflow);
endinterface

// File: rtl/dac_driver_lut.sv
// GPIO decode (synchronised w_clk edge), pulse config registers and amplitude LUT.
// LUT read data appears one cycle after rd_en_i; never stalls.
module dac_driver_lut
  import dac_driver_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [31:0]                 gpio_i,
  input  logic                        rd_en_i,
  input  logic [num_bits-1:0]         rd_addr_i,
  output logic [dac_sample_width-1:0] rd_dat_o,
  output logic [2:0]                  pulse_pos_o,
  output logic [3:0]                  pulse_len_o
);
  logic                        sync1_q, sync2_q, prev_q;
  logic [num_bits-1:0]         idx_q;
  logic [7:0]                  lo_q;
  logic [2:0]                  pos_q;
  logic [3:0]                  len_q;
  logic [dac_sample_width-1:0] rd_q;
  logic [dac_sample_width-1:0] mem [2**num_bits];

  logic       wr_stb;
  logic [3:0] addr;
  logic [7:0] dat;
  logic       unused_gpio;

  assign wr_stb      = sync2_q & ~prev_q;
  assign addr        = gpio_i[gpio_addr_hi:gpio_addr_lo];
  assign dat         = gpio_i[gpio_data_hi:gpio_data_lo];
  assign unused_gpio = ^gpio_i[gpio_w_clk_bit-1:gpio_addr_hi+1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      idx_q   <= '0;
      lo_q    <= '0;
      pos_q   <= '0;
      len_q   <= 4'd1;
      rd_q    <= '0;
    end else begin
      sync1_q <= gpio_i[gpio_w_clk_bit];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (wr_stb) begin
        case (addr)
          addr_reg:      idx_q <= dat[num_bits-1:0];
          data_lo_reg:   lo_q  <= dat;
          pulse_pos_reg: pos_q <= dat[2:0];
          pulse_len_reg: len_q <= dat[3:0];
          default: ;
        endcase
      end
      if (rd_en_i) rd_q <= mem[rd_addr_i];
    end
  end

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_stb && addr == data_hi_reg) mem[idx_q] <= {dat, lo_q};
  end

  assign rd_dat_o    = rd_q;
  assign pulse_pos_o = pos_q;
  assign pulse_len_o = len_q;
endmodule

// File: rtl/dac_driver.sv
// Maps queued spin values through the LUT into rectangular pulses on a 128-bit DAC stream.
// val_vld to first pulse word: 3 cycles; tdata only advances on tvalid&tready, values dropped when FIFO full.
module dac_driver
  import dac_driver_pkg::*;
(
  input logic         clk_i,
  input logic         rst_ni,
  dac_driver_if.slave bus
);
  localparam int              PW      = $clog2(fifo_depth);
  localparam logic [PW:0]     FULL    = (PW+1)'(fifo_depth);
  localparam logic [PW:0]     CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);

  logic [1:0]                  state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d, len_q, len_d;
  logic [dac_sample_width-1:0] amp_q, amp_d;
  dac_word_t                   tdata_q, tdata_d;
  logic                        tvalid_q, en_prev_q, ovf_q, ovf_d;

  logic [num_bits-1:0]         fifo_mem [fifo_depth];
  logic [PW-1:0]               rd_ptr_q, wr_ptr_q;
  logic [PW:0]                 fcount_q;

  logic                        empty, full, xfer, last, pop, push_req, push;
  logic [dac_sample_width-1:0] lut_dat;
  logic [2:0]                  cfg_pos;
  logic [3:0]                  cfg_len;

  dac_driver_lut u_lut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .gpio_i      (bus.gpio),
    .rd_en_i     (pop),
    .rd_addr_i   (fifo_mem[rd_ptr_q]),
    .rd_dat_o    (lut_dat),
    .pulse_pos_o (cfg_pos),
    .pulse_len_o (cfg_len)
  );

  assign empty    = (fcount_q == '0);
  assign full     = (fcount_q == FULL);
  assign xfer     = tvalid_q & bus.m_axis_tready;
  assign last     = (cnt_q == len_q - 4'd1);
  assign push_req = bus.val_vld & bus.dac_en;
  assign push     = push_req & (~full | pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    amp_d   = amp_q;
    tdata_d = tdata_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && bus.dac_en) begin
          pop     = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      // The zero word on the bus must transfer before word 0 may replace it.
      ST_LOOKUP: begin
        if (!bus.dac_en) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          amp_d   = lut_dat;
          len_d   = (cfg_len == 4'd0) ? 4'd1 : cfg_len;
          cnt_d   = 4'd0;
          tdata_d = build_word(lut_dat, cfg_pos, 1'b1);
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (xfer) begin
          if (!bus.dac_en || last) begin
            tdata_d = '0;
            state_d = ST_IDLE;
            if (bus.dac_en && !empty) begin
              pop     = 1'b1;
              state_d = ST_LOOKUP;
            end
          end else begin
            cnt_d   = cnt_q + 4'd1;
            tdata_d = build_word(amp_q, 3'd0, 1'b0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ovf_d = ovf_q;
    if (bus.dac_en && !en_prev_q) ovf_d = 1'b0;
    if (push_req && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.val;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= 4'd1;
      amp_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      en_prev_q <= 1'b0;
      ovf_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      fcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      amp_q     <= amp_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= 1'b1;
      en_prev_q <= bus.dac_en;
      ovf_q     <= ovf_d;
      if (!bus.dac_en) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        fcount_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        case ({push, pop})
          2'b10:   fcount_q <= fcount_q + CNT_ONE;
          2'b01:   fcount_q <= fcount_q - CNT_ONE;
          default: ;
        endcase
      end
    end
  end

  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.busy          = (state_q != ST_IDLE) || !empty;
  assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_dac_driver.sv
// Directed bench for dac_driver: table of single-pulse vectors plus hand sequences
// for stall, overflow burst, mid-pulse config, dac_en drop and reset.
module tb_dac_driver;
  import dac_driver_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dac_driver_if bus ();

  dac_driver dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0]   idx;
    logic [15:0]  amp;
    logic [2:0]   pos;
    logic [3:0]   len_cfg;
    int           exp_len;
    logic [127:0] exp_w0;
    logic [127:0] exp_wn;
  } vec_t;

  vec_t         vecs [4];
  logic [127:0] exp_burst [31];
  logic [15:0]  burst_amp [5];
  logic [3:0]   burst_val [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic gpio_write(input logic [3:0] a, input logic [7:0] d);
    bus.gpio = {1'b0, 19'd0, a, d};
    tick();
    bus.gpio = {1'b1, 19'd0, a, d};
    repeat (4) tick();
    bus.gpio = {1'b0, 19'd0, a, d};
    repeat (3) tick();
  endtask

  task automatic lut_write(input logic [3:0] idx, input logic [15:0] amp);
    gpio_write(addr_reg, {4'd0, idx});
    gpio_write(data_lo_reg, amp[7:0]);
    gpio_write(data_hi_reg, amp[15:8]);
  endtask

  task automatic strobe(input logic [3:0] v);
    bus.val     = v;
    bus.val_vld = 1'b1;
    tick();
    bus.val_vld = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{4'd5,  16'h1234, 3'd0, 4'd1, 1, {8{16'h1234}}, {8{16'h1234}}};
    vecs[1] = '{4'd2,  16'hF000, 3'd3, 4'd3, 3,
                128'hF000_F000_F000_F000_F000_0000_0000_0000, {8{16'hF000}}};
    vecs[2] = '{4'd7,  16'h8001, 3'd7, 4'd0, 1,
                128'h8001_0000_0000_0000_0000_0000_0000_0000, {8{16'h8001}}};
    vecs[3] = '{4'd15, 16'h00FF, 3'd1, 4'd2, 2,
                128'h00FF_00FF_00FF_00FF_00FF_00FF_00FF_0000, {8{16'h00FF}}};

    bus.gpio = '0;
    bus.val = '0;
    bus.val_vld = 1'b0;
    bus.dac_en = 1'b0;
    bus.m_axis_tready = 1'b1;

    repeat (3) tick();
    chk("rst_tvalid", {127'd0, bus.m_axis_tvalid}, 128'd0);
    chk("rst_tdata", bus.m_axis_tdata, 128'd0);
    chk("rst_busy", {127'd0, bus.busy}, 128'd0);
    chk("rst_overflow", {127'd0, bus.overflow}, 128'd0);
    rst_n = 1'b1;
    tick();
    chk("tvalid_after_rst", {127'd0, bus.m_axis_tvalid}, 128'd1);
    chk("idle_word_zero", bus.m_axis_tdata, 128'd0);
    bus.dac_en = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      lut_write(vecs[v].idx, vecs[v].amp);
      gpio_write(pulse_pos_reg, {5'd0, vecs[v].pos});
      gpio_write(pulse_len_reg, {4'd0, vecs[v].len_cfg});
      strobe(vecs[v].idx);
      chk($sformatf("vec%0d_pre1", v), bus.m_axis_tdata, 128'd0);
      chk($sformatf("vec%0d_busy", v), {127'd0, bus.busy}, 128'd1);
      tick();
      chk($sformatf("vec%0d_pre2", v), bus.m_axis_tdata, 128'd0);
      tick();
      chk($sformatf("vec%0d_w0", v), bus.m_axis_tdata, vecs[v].exp_w0);
      for (int k = 1; k < vecs[v].exp_len; k++) begin
        tick();
        chk($sformatf("vec%0d_w%0d", v, k), bus.m_axis_tdata, vecs[v].exp_wn);
      end
      tick();
      chk($sformatf("vec%0d_post", v), bus.m_axis_tdata, 128'd0);
      chk($sformatf("vec%0d_busy_post", v), {127'd0, bus.busy}, 128'd0);
      repeat (2) tick();
    end

    // tready stall during word 1 of a pos=3 len=3 pulse
    gpio_write(pulse_pos_reg, 8'd3);
    gpio_write(pulse_len_reg, 8'd3);
    strobe(4'd2);
    repeat (2) tick();
    chk("stall_w0", bus.m_axis_tdata, 128'hF000_F000_F000_F000_F000_0000_0000_0000);
    tick();
    bus.m_axis_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_hold%0d", k), bus.m_axis_tdata, {8{16'hF000}});
      tick();
    end
    chk("stall_busy", {127'd0, bus.busy}, 128'd1);
    bus.m_axis_tready = 1'b1;
    tick();
    chk("stall_w2", bus.m_axis_tdata, {8{16'hF000}});
    tick();
    chk("stall_post", bus.m_axis_tdata, 128'd0);
    repeat (2) tick();

    // Six back-to-back strobes, len=4: the first entry is popped while the burst
    // is still arriving, so five values are kept and the sixth is dropped.
    lut_write(4'd1, 16'h1111);
    lut_write(4'd3, 16'h3333);
    lut_write(4'd4, 16'h4444);
    lut_write(4'd6, 16'h6666);
    gpio_write(pulse_pos_reg, 8'd0);
    gpio_write(pulse_len_reg, 8'd4);
    burst_val = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd5, 4'd2};
    burst_amp = '{16'h1111, 16'h3333, 16'h4444, 16'h6666, 16'h1234};
    for (int k = 0; k < 31; k++) exp_burst[k] = '0;
    for (int p = 0; p < 5; p++)
      for (int w = 0; w < 4; w++) exp_burst[3 + 5*p + w] = {8{burst_amp[p]}};
    for (int i = 0; i < 30; i++) begin
      bus.val_vld = (i < 6);
      bus.val = (i < 6) ? burst_val[i] : 4'd0;
      tick();
      chk($sformatf("burst_c%0d", i + 1), bus.m_axis_tdata, exp_burst[i + 1]);
    end
    bus.val_vld = 1'b0;
    chk("burst_overflow", {127'd0, bus.overflow}, 128'd1);
    chk("burst_busy_end", {127'd0, bus.busy}, 128'd0);
    bus.dac_en = 1'b0;
    tick();
    chk("overflow_sticky_en0", {127'd0, bus.overflow}, 128'd1);
    bus.dac_en = 1'b1;
    tick();
    chk("overflow_cleared", {127'd0, bus.overflow}, 128'd0);

    // pos rewritten mid-pulse: current pulse untouched, next pulse uses it
    lut_write(4'd2, 16'hF000);
    gpio_write(pulse_pos_reg, 8'd2);
    gpio_write(pulse_len_reg, 8'd15);
    strobe(4'd2);
    repeat (2) tick();
    chk("midpos_w0", bus.m_axis_tdata, 128'hF000_F000_F000_F000_F000_F000_0000_0000);
    gpio_write(pulse_pos_reg, 8'd5);
    n = 0;
    for (int g = 0; g < 20 && bus.m_axis_tdata != '0; g++) begin
      chk($sformatf("midpos_w%0d", 8 + g), bus.m_axis_tdata, {8{16'hF000}});
      n++;
      tick();
    end
    chk("midpos_remaining_words", 128'(n), 128'd7);
    gpio_write(pulse_len_reg, 8'd0);
    strobe(4'd2);
    repeat (2) tick();
    chk("newpos_w0", bus.m_axis_tdata, 128'hF000_F000_F000_0000_0000_0000_0000_0000);
    tick();
    chk("len0_post", bus.m_axis_tdata, 128'd0);
    repeat (2) tick();

    // dac_en drop during word 2 of len=8, with a second value queued
    gpio_write(pulse_pos_reg, 8'd0);
    gpio_write(pulse_len_reg, 8'd8);
    strobe(4'd1);
    strobe(4'd3);
    tick();
    chk("endrop_w0", bus.m_axis_tdata, {8{16'h1111}});
    repeat (2) tick();
    chk("endrop_w2", bus.m_axis_tdata, {8{16'h1111}});
    bus.dac_en = 1'b0;
    tick();
    chk("endrop_zero", bus.m_axis_tdata, 128'd0);
    chk("endrop_busy", {127'd0, bus.busy}, 128'd0);
    bus.dac_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("flushed_c%0d", k), {bus.m_axis_tdata[126:0], bus.busy}, 128'd0);
    end

    // asynchronous reset in the middle of a pulse
    strobe(4'd5);
    repeat (3) tick();
    chk("rstmid_w1", bus.m_axis_tdata, {8{16'h1234}});
    rst_n = 1'b0;
    #1;
    chk("rstmid_tvalid", {127'd0, bus.m_axis_tvalid}, 128'd0);
    chk("rstmid_tdata", bus.m_axis_tdata, 128'd0);
    chk("rstmid_busy", {127'd0, bus.busy}, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid_tvalid_back", {127'd0, bus.m_axis_tvalid}, 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
